// File: rtl/svm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : svm_pkg
//  Description : Shared constants and types for the SVM classifier core and
//                its stream feeder (support-vector counts, image length,
//                segment phase encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package svm_pkg;

   // Words per image and per support vector
   localparam int IMG_LEN   = 784;
   // Number of one-vs-rest classifier cores
   localparam int NUM_CORES = 10;
   // Width of the support-vector index counter
   localparam int SV_W      = 10;

   // Support vectors held by each core, in memory order
   localparam int SV_NUM [NUM_CORES] = '{361, 267, 581, 632, 80, 513, 376, 432, 751, 683};

   // Kind of segment currently being fed to the core
   typedef enum logic [1:0] {
      PH_IMG    = 2'd0,
      PH_SV     = 2'd1,
      PH_LAMBDA = 2'd2,
      PH_BIAS   = 2'd3
   } phase_t;

   // Packs SV_NUM into a vector so it can be carried as a module parameter
   function automatic logic [NUM_CORES-1:0][SV_W-1:0] sv_num_vec();
      logic [NUM_CORES-1:0][SV_W-1:0] v;
      for (int k = 0; k < NUM_CORES; k++) begin
         v[k] = SV_W'(SV_NUM[k]);
      end
      return v;
   endfunction

   localparam logic [NUM_CORES-1:0][SV_W-1:0] SV_NUM_VEC = sv_num_vec();

endpackage
`default_nettype wire

// File: rtl/svm_stream_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : svm_stream_feeder_if
//  Description : Bundles the outgoing data stream (sdata/svalid/sready) and
//                the linear memory read port used by the stream feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface svm_stream_feeder_if #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 22
);
   logic [WIDTH-1:0]      sdata;
   logic                  svalid;
   logic                  sready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_en;
   logic [WIDTH-1:0]      mem_data;

   // Feeder side: produces the stream and issues memory reads
   modport master (
      output sdata, svalid, mem_addr, mem_en,
      input  sready, mem_data
   );

   // Core/memory side: consumes the stream and answers reads
   modport slave (
      input  sdata, svalid, mem_addr, mem_en,
      output sready, mem_data
   );
endinterface
`default_nettype wire

// File: rtl/svm_stream_feeder_skid_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : skid_fifo2
//  Description : Two-entry first-word-fall-through buffer. Slot 0 is always
//                the head, so the head value is stable while not popped.
//  Revision    : 1.0 - initial release
// ============================================================================
module skid_fifo2 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count
);
   localparam logic [1:0] c_ONE  = 2'd1;
   localparam logic [1:0] c_FULL = 2'd2;

   logic [WIDTH-1:0] r_slot0;
   logic [WIDTH-1:0] r_slot1;
   logic [1:0]       r_count;
   logic             w_do_pop;
   logic             w_do_push;

   // Pops need data; pushes need room unless a pop frees a slot this cycle
   assign w_do_pop  = pop && (r_count != 2'd0);
   assign w_do_push = push && ((r_count != c_FULL) || w_do_pop);

   // Slot shifting and occupancy tracking
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_slot0 <= '0;
         r_slot1 <= '0;
         r_count <= '0;
      end else begin
         case ({w_do_push, w_do_pop})
            2'b10: begin
               if (r_count == 2'd0) r_slot0 <= push_data;
               else                 r_slot1 <= push_data;
               r_count <= r_count + c_ONE;
            end
            2'b01: begin
               r_slot0 <= r_slot1;
               r_count <= r_count - c_ONE;
            end
            2'b11: begin
               if (r_count == c_ONE) begin
                  r_slot0 <= push_data;
               end else begin
                  r_slot0 <= r_slot1;
                  r_slot1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = r_slot0;
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/svm_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : svm_stream_feeder
//  Description : Streams image, support vectors, lambdas and biases from a
//                linear memory to the SVM core, one segment per core
//                interrupt, through a two-entry skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module svm_stream_feeder
   import svm_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 22,
   parameter int IMG_LEN    = svm_pkg::IMG_LEN,
   parameter logic [NUM_CORES-1:0][SV_W-1:0] SV_COUNTS = SV_NUM_VEC
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic done,
   output logic error,
   input  logic intr,
   svm_stream_feeder_if.master bus
);
   localparam int c_CNT_W = $clog2(IMG_LEN + 1);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_WAIT_INTR  = 2'd1;
   localparam logic [1:0] S_STREAM     = 2'd2;
   localparam logic [1:0] S_WAIT_FINAL = 2'd3;

   localparam logic [c_CNT_W-1:0]    c_SEG_LONG  = c_CNT_W'(IMG_LEN);
   localparam logic [c_CNT_W-1:0]    c_CNT_ONE   = 1;
   localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = 1;
   localparam logic [SV_W-1:0]       c_SV_ONE    = 1;
   localparam logic [3:0]            c_CORE_ONE  = 1;
   localparam logic [3:0]            c_LAST_CORE = 4'(NUM_CORES - 1);

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [3:0]            r_core;
   logic [SV_W-1:0]       r_sv;
   phase_t                r_phase;
   logic [c_CNT_W-1:0]    r_issue_left;
   logic [c_CNT_W-1:0]    r_xfer_left;
   logic                  r_inflight;
   logic                  r_pending;
   logic                  r_error;
   logic                  r_done;

   logic [1:0]            w_fifo_count;
   logic [WIDTH-1:0]      w_fifo_head;
   logic                  w_fifo_push;
   logic                  w_fifo_pop;
   logic                  w_bypass;
   logic                  w_svalid;
   logic                  w_xfer;
   logic [1:0]            w_occupancy;
   logic                  w_issue;
   logic                  w_start_ok;
   logic                  w_go;
   logic                  w_final;
   logic                  w_seg_end;
   logic                  w_last_sv;
   logic                  w_last_core;
   logic [c_CNT_W-1:0]    w_seg_len;

   // ------------------------------------------------------------------
   // Stream output path. When the buffer is empty, returning memory data
   // is presented directly so the first word appears one cycle after the
   // read; a word not taken that cycle drops into the buffer unchanged.
   // ------------------------------------------------------------------
   assign w_bypass    = (w_fifo_count == 2'd0) && r_inflight;
   assign w_svalid    = (w_fifo_count != 2'd0) || r_inflight;
   assign w_xfer      = w_svalid && bus.sready;
   assign w_fifo_push = r_inflight && !(w_bypass && bus.sready);
   assign w_fifo_pop  = (w_fifo_count != 2'd0) && bus.sready;

   assign bus.svalid   = w_svalid;
   assign bus.sdata    = w_bypass ? bus.mem_data : w_fifo_head;
   assign bus.mem_addr = r_addr;

   skid_fifo2 #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (w_fifo_push),
      .push_data (bus.mem_data),
      .pop       (w_fifo_pop),
      .head      (w_fifo_head),
      .count     (w_fifo_count)
   );

   // ------------------------------------------------------------------
   // Control decodes
   // ------------------------------------------------------------------
   // Buffered words plus the read in flight must leave room for one more
   assign w_occupancy = w_fifo_count + {1'b0, r_inflight};
   assign w_issue     = (r_state == S_STREAM) && (r_issue_left != '0) && (w_occupancy < 2'd2);
   assign w_start_ok  = (r_state == S_IDLE) && start;
   assign w_go        = (r_state == S_WAIT_INTR) && (intr || r_pending);
   assign w_final     = (r_state == S_WAIT_FINAL) && (intr || r_pending);
   assign w_seg_end   = (r_state == S_STREAM) && w_xfer && (r_xfer_left == c_CNT_ONE);
   assign w_last_sv   = (r_sv == (SV_COUNTS[r_core] - c_SV_ONE));
   assign w_last_core = (r_core == c_LAST_CORE);
   assign w_seg_len   = ((r_phase == PH_IMG) || (r_phase == PH_SV)) ? c_SEG_LONG : c_CNT_ONE;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // FSM next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:       if (w_start_ok) w_next_state = S_WAIT_INTR;
         S_WAIT_INTR:  if (w_go)       w_next_state = S_STREAM;
         S_STREAM: begin
            if (w_seg_end) begin
               if ((r_phase == PH_BIAS) && w_last_core) w_next_state = S_WAIT_FINAL;
               else                                     w_next_state = S_WAIT_INTR;
            end
         end
         S_WAIT_FINAL: if (w_final)    w_next_state = S_IDLE;
         default:                      w_next_state = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy       = (r_state != S_IDLE);
      bus.mem_en = w_issue;
   end

   // Address, segment word counts and phase/sv/core position
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr       <= '0;
         r_core       <= '0;
         r_sv         <= '0;
         r_phase      <= PH_IMG;
         r_issue_left <= '0;
         r_xfer_left  <= '0;
         r_inflight   <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         r_done     <= w_final;
         if (w_start_ok) begin
            r_addr       <= '0;
            r_core       <= '0;
            r_sv         <= '0;
            r_phase      <= PH_IMG;
            r_issue_left <= '0;
            r_xfer_left  <= '0;
         end else if (w_go) begin
            r_issue_left <= w_seg_len;
            r_xfer_left  <= w_seg_len;
         end else begin
            if (w_issue) begin
               r_addr       <= r_addr + c_ADDR_ONE;
               r_issue_left <= r_issue_left - c_CNT_ONE;
            end
            if (w_xfer) begin
               r_xfer_left <= r_xfer_left - c_CNT_ONE;
            end
            if (w_seg_end) begin
               case (r_phase)
                  PH_IMG:    r_phase <= PH_SV;
                  PH_SV:     r_phase <= PH_LAMBDA;
                  PH_LAMBDA: begin
                     if (w_last_sv) begin
                        r_phase <= PH_BIAS;
                     end else begin
                        r_sv    <= r_sv + c_SV_ONE;
                        r_phase <= PH_SV;
                     end
                  end
                  PH_BIAS: begin
                     // After the last core's bias the position is left as is;
                     // only the final interrupt remains
                     if (!w_last_core) begin
                        r_core  <= r_core + c_CORE_ONE;
                        r_sv    <= '0;
                        r_phase <= PH_SV;
                     end
                  end
                  default: r_phase <= PH_IMG;
               endcase
            end
         end
      end
   end

   // One-deep interrupt memory and sticky overrun flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= 1'b0;
         r_error   <= 1'b0;
      end else if (w_start_ok) begin
         r_pending <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         case (r_state)
            S_STREAM: begin
               if (intr) begin
                  if (r_pending) r_error   <= 1'b1;
                  else           r_pending <= 1'b1;
               end
            end
            // A held pulse is consumed here; a fresh pulse arriving in the
            // same cycle becomes the next held one
            S_WAIT_INTR:  if (r_pending) r_pending <= intr;
            S_WAIT_FINAL: r_pending <= 1'b0;
            default: ;
         endcase
      end
   end

   assign done  = r_done;
   assign error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_svm_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_svm_stream_feeder
//  Description : Self-checking bench for svm_stream_feeder with a reduced
//                image length and support-vector table so complete feeds
//                fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_svm_stream_feeder;
   localparam int TB_W   = 16;
   localparam int TB_AW  = 22;
   localparam int TB_IMG = 8;
   // Core 9 first (MSB) down to core 0: counts 3,1,2,1,1,2,1,3,1,2
   localparam logic [9:0][9:0] TB_SV = {10'd3, 10'd1, 10'd2, 10'd1, 10'd1,
                                        10'd2, 10'd1, 10'd3, 10'd1, 10'd2};

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic busy;
   logic done;
   logic error;
   logic intr;

   svm_stream_feeder_if #(.WIDTH(TB_W), .ADDR_WIDTH(TB_AW)) bus();

   svm_stream_feeder #(
      .WIDTH      (TB_W),
      .ADDR_WIDTH (TB_AW),
      .IMG_LEN    (TB_IMG),
      .SV_COUNTS  (TB_SV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .busy  (busy),
      .done  (done),
      .error (error),
      .intr  (intr),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference: support-vector counts per core, segment lengths, boundaries
   int sv_cfg [10] = '{2, 1, 3, 1, 2, 1, 1, 2, 1, 3};
   int seg_len [$];
   int bound [$];
   int nseg;
   int total;

   logic [15:0] got [$];
   int          iss [$];
   int          chk_idx = 0;
   int          rel = 0;
   int          done_cnt = 0;
   bit          rnd_mode = 1'b0;
   bit          hold_val = 1'b1;
   bit          prev_stall = 1'b0;
   logic [15:0] prev_data;

   function automatic logic [15:0] mem_word(int a);
      logic [31:0] t;
      t = a * 32'd40503;
      return t[15:0] ^ t[31:16] ^ 16'h1234;
   endfunction

   function automatic int rel_bound();
      if (rel == 0) return 0;
      if (rel > nseg) return bound[nseg-1];
      return bound[rel-1];
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory with one-cycle read latency
   always @(posedge clk) begin
      if (bus.mem_en) bus.mem_data <= mem_word(int'(bus.mem_addr));
   end

   // Ready driver: held value or coin flip each cycle
   always @(posedge clk) begin
      #1;
      bus.sready = rnd_mode ? 1'($urandom_range(0, 1)) : hold_val;
   end

   // Mid-cycle monitor: transfers, reads, stall stability, done pulses
   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (prev_stall) begin
            chk("stall_valid_hold", 32'(bus.svalid), 32'd1);
            chk("stall_data_hold", 32'(bus.sdata), 32'(prev_data));
         end
         prev_stall = bus.svalid && !bus.sready;
         prev_data  = bus.sdata;
         if (bus.svalid && bus.sready) got.push_back(bus.sdata);
         if (bus.mem_en) begin
            chk("rd_addr_seq", 32'(bus.mem_addr), 32'(iss.size()));
            chk("rd_in_segment", 32'(int'(bus.mem_addr) < rel_bound()), 32'd1);
            iss.push_back(int'(bus.mem_addr));
         end
      end
   end

   task automatic compare_new();
      while (chk_idx < got.size()) begin
         chk("word_value", 32'(got[chk_idx]), 32'(mem_word(chk_idx)));
         chk_idx++;
      end
   endtask

   task automatic wait_words(int n, string tag);
      int k = 0;
      while (got.size() < n && k < 3000) begin
         @(posedge clk);
         k++;
      end
      #2;
      chk(tag, 32'(got.size()), 32'(n));
      compare_new();
   endtask

   task automatic pulse_intr(bit counts);
      @(posedge clk); #1;
      intr = 1'b1;
      if (counts) rel++;
      @(posedge clk); #1;
      intr = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic restart_model();
      got.delete();
      iss.delete();
      chk_idx = 0;
      rel = 0;
   endtask

   initial begin
      int acc;
      bit seen;

      // Build the segment table from the memory layout rules
      seg_len.push_back(TB_IMG);
      for (int k = 0; k < 10; k++) begin
         for (int s = 0; s < sv_cfg[k]; s++) begin
            seg_len.push_back(TB_IMG);
            seg_len.push_back(1);
         end
         seg_len.push_back(1);
      end
      acc = 0;
      foreach (seg_len[i]) begin
         acc += seg_len[i];
         bound.push_back(acc);
      end
      nseg  = seg_len.size();
      total = acc;

      // ---- Reset values
      reset = 1'b0; start = 1'b0; intr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_svalid", 32'(bus.svalid), 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_sdata", 32'(bus.sdata), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // ---- Interrupt while idle is ignored
      pulse_intr(1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("idle_intr_busy", 32'(busy), 32'd0);
         chk("idle_intr_mem_en", 32'(bus.mem_en), 32'd0);
      end

      // ---- Start, then image segment latency
      restart_model();
      pulse_start();
      @(negedge clk);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_no_read", 32'(bus.mem_en), 32'd0);
      repeat (5) @(posedge clk);
      pulse_intr(1'b1);
      @(negedge clk);
      chk("lat_mem_en_n1", 32'(bus.mem_en), 32'd1);
      chk("lat_svalid_n1", 32'(bus.svalid), 32'd0);
      chk("lat_addr_n1", 32'(bus.mem_addr), 32'd0);
      @(negedge clk);
      chk("lat_svalid_n2", 32'(bus.svalid), 32'd1);
      chk("lat_sdata_n2", 32'(bus.sdata), 32'(mem_word(0)));

      // ---- Early interrupt during the image is held for the SV segment
      pulse_intr(1'b1);
      wait_words(TB_IMG, "image_words");
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.mem_en) seen = 1'b1;
      end
      chk("pending_autostart", 32'(seen), 32'd1);

      // ---- SV segment under random backpressure; start while busy ignored
      rnd_mode = 1'b1;
      pulse_start();
      wait_words(bound[1], "sv0_words");
      repeat (4) @(posedge clk);
      #2;
      chk("sv0_no_overread", 32'(iss.size()), 32'(bound[1]));
      chk("sv0_idle_stream", 32'(bus.svalid), 32'd0);
      chk("sv0_busy", 32'(busy), 32'd1);

      // ---- Three interrupts in one segment raise the overrun flag
      rnd_mode = 1'b0;
      hold_val = 1'b0;
      pulse_intr(1'b1);
      repeat (3) @(posedge clk);
      pulse_intr(1'b1);
      @(negedge clk);
      chk("one_pending_no_err", 32'(error), 32'd0);
      pulse_intr(1'b0);
      @(negedge clk);
      chk("overrun_error", 32'(error), 32'd1);
      rnd_mode = 1'b1;

      // ---- Remainder of the feed, one interrupt per drained segment
      while (rel < nseg) begin
         wait_words(bound[rel-1], "seg_words");
         repeat (2) @(posedge clk);
         pulse_intr(1'b1);
      end
      wait_words(total, "all_words");
      chk("final_read_addr", 32'(iss[iss.size()-1]), 32'(total - 1));
      chk("total_reads", 32'(iss.size()), 32'(total));
      chk("wait_final_busy", 32'(busy), 32'd1);
      chk("no_early_done", 32'(done_cnt), 32'd0);
      pulse_intr(1'b1);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_idle", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("error_sticky", 32'(error), 32'd1);

      // ---- New start clears the overrun flag
      rnd_mode = 1'b0;
      hold_val = 1'b1;
      restart_model();
      pulse_start();
      @(negedge clk);
      chk("start_clears_error", 32'(error), 32'd0);

      // ---- Reset in the middle of a segment
      pulse_intr(1'b1);
      for (int c = 0; c < 50 && got.size() < 4; c++) @(posedge clk);
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      chk("async_svalid", 32'(bus.svalid), 32'd0);
      chk("async_mem_en", 32'(bus.mem_en), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_sdata", 32'(bus.sdata), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      restart_model();
      pulse_start();
      pulse_intr(1'b1);
      @(negedge clk);
      chk("restart_addr0", 32'(bus.mem_addr), 32'd0);
      wait_words(TB_IMG, "restart_image");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
